// File: rtl/tmdb_filter_pkg.sv
// Shared widths, default coefficient set and output saturation for the
// D5/D6 tile-cell energy filters.
package tmdb_filter_pkg;

  localparam int NTAPS  = 7;
  localparam int ADC_W  = 12;
  localparam int COEF_W = 10;
  localparam int SHIFT  = 4;
  localparam int OUT_W  = 19;
  localparam int ACC_W  = 26;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 26'sd262143;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -26'sd262144;

  // Unity gain after the shift: c[0] = 2^SHIFT, remaining taps zero.
  localparam logic signed [COEF_W-1:0] DEFAULT_COEF [NTAPS] = '{
    10'sd16, 10'sd0, 10'sd0, 10'sd0, 10'sd0, 10'sd0, 10'sd0
  };

  function automatic logic signed [OUT_W-1:0] sat19(input logic signed [ACC_W-1:0] v);
    logic signed [OUT_W-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[OUT_W-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[OUT_W-1:0];
    end else begin
      r = v[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_channel.sv
// One cell's filter: pedestal subtraction, tap line, registered products,
// pairwise adder tree, full sum, then arithmetic shift and saturation.
module fir_channel #(
  parameter int NTAPS  = tmdb_filter_pkg::NTAPS,
  parameter int ADC_W  = tmdb_filter_pkg::ADC_W,
  parameter int COEF_W = tmdb_filter_pkg::COEF_W,
  parameter int SHIFT  = tmdb_filter_pkg::SHIFT
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [ADC_W-1:0]                          adc_i,
  input  logic [ADC_W-1:0]                          ped_i,
  input  logic signed [COEF_W-1:0]                  coef_i [NTAPS],
  output logic signed [tmdb_filter_pkg::OUT_W-1:0]  cell_o
);
  import tmdb_filter_pkg::*;

  localparam int X_W    = ADC_W + 1;
  localparam int PROD_W = X_W + COEF_W;
  localparam int NPAIR  = (NTAPS + 1) / 2;

  logic signed [X_W-1:0]    x_s;
  logic signed [X_W-1:0]    tap_q   [NTAPS];
  logic signed [PROD_W-1:0] prod_q  [NTAPS];
  logic signed [PROD_W-1:0] prod_pad_s [2*NPAIR];
  logic signed [ACC_W-1:0]  pair_q  [NPAIR];
  logic signed [ACC_W-1:0]  sum_d;
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  shifted_s;
  logic signed [OUT_W-1:0]  cell_q;

  assign x_s       = $signed({1'b0, adc_i}) - $signed({1'b0, ped_i});
  assign shifted_s = sum_q >>> SHIFT;
  assign cell_o    = cell_q;

  // Odd tap counts leave the last pair with a zero partner.
  always_comb begin
    for (int k = 0; k < 2*NPAIR; k++) begin
      prod_pad_s[k] = '0;
    end
    for (int k = 0; k < NTAPS; k++) begin
      prod_pad_s[k] = prod_q[k];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int p = 0; p < NPAIR; p++) begin
      sum_d = sum_d + pair_q[p];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NTAPS; k++) begin
        tap_q[k]  <= '0;
        prod_q[k] <= '0;
      end
      for (int p = 0; p < NPAIR; p++) begin
        pair_q[p] <= '0;
      end
      sum_q  <= '0;
      cell_q <= '0;
    end else begin
      tap_q[0] <= x_s;
      for (int k = 1; k < NTAPS; k++) begin
        tap_q[k] <= tap_q[k-1];
      end
      for (int k = 0; k < NTAPS; k++) begin
        prod_q[k] <= PROD_W'(tap_q[k]) * PROD_W'(coef_i[k]);
      end
      for (int p = 0; p < NPAIR; p++) begin
        pair_q[p] <= ACC_W'(prod_pad_s[2*p]) + ACC_W'(prod_pad_s[2*p+1]);
      end
      sum_q  <= sum_d;
      cell_q <= sat19(shifted_s);
    end
  end

endmodule

// File: rtl/energy_filter.sv
// D5/D6 matched-filter energy reconstruction: shared shadow/active
// coefficient banks, warm-up tracking and two filter channels.
module energy_filter #(
  parameter int NTAPS  = tmdb_filter_pkg::NTAPS,
  parameter int ADC_W  = tmdb_filter_pkg::ADC_W,
  parameter int COEF_W = tmdb_filter_pkg::COEF_W,
  parameter int SHIFT  = tmdb_filter_pkg::SHIFT
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [ADC_W-1:0]                          adc5,
  input  logic [ADC_W-1:0]                          adc6,
  input  logic [ADC_W-1:0]                          ped5,
  input  logic [ADC_W-1:0]                          ped6,
  input  logic                                      coef_we,
  input  logic [2:0]                                coef_addr,
  input  logic signed [COEF_W-1:0]                  coef_data,
  input  logic                                      coef_commit,
  output logic signed [tmdb_filter_pkg::OUT_W-1:0]  cell5,
  output logic signed [tmdb_filter_pkg::OUT_W-1:0]  cell6,
  output logic                                      out_valid
);
  import tmdb_filter_pkg::*;

  // First full window leaves the 4-stage pipeline after edge NTAPS+3.
  localparam int VALID_AT = NTAPS + 3;
  localparam int CNT_W    = $clog2(VALID_AT + 1);

  logic signed [COEF_W-1:0] shadow_q [NTAPS];
  logic signed [COEF_W-1:0] shadow_d [NTAPS];
  logic signed [COEF_W-1:0] active_q [NTAPS];
  logic signed [COEF_W-1:0] active_d [NTAPS];
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  logic                     valid_q;
  logic                     valid_d;

  // Commit copies the shadow as it stood before this edge; a same-cycle write lands in the shadow only.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (coef_commit) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
    if (coef_we && (int'(coef_addr) < NTAPS)) begin
      shadow_d[coef_addr] = coef_data;
    end else begin
      shadow_d = shadow_q;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (cnt_q == CNT_W'(VALID_AT)) begin
      cnt_d   = cnt_q;
      valid_d = 1'b1;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= DEFAULT_COEF;
      active_q <= DEFAULT_COEF;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid = valid_q;

  fir_channel #(
    .NTAPS (NTAPS),
    .ADC_W (ADC_W),
    .COEF_W(COEF_W),
    .SHIFT (SHIFT)
  ) u_cell5 (
    .clk_i (clk),
    .rst_i (rst),
    .adc_i (adc5),
    .ped_i (ped5),
    .coef_i(active_q),
    .cell_o(cell5)
  );

  fir_channel #(
    .NTAPS (NTAPS),
    .ADC_W (ADC_W),
    .COEF_W(COEF_W),
    .SHIFT (SHIFT)
  ) u_cell6 (
    .clk_i (clk),
    .rst_i (rst),
    .adc_i (adc6),
    .ped_i (ped6),
    .coef_i(active_q),
    .cell_o(cell6)
  );

endmodule

// File: tb/tb_energy_filter.sv
// Bench for energy_filter: directed scenarios with literal expectations
// plus randomized traffic, all checked against a behavioural model.
module tb_energy_filter;

  localparam int NT    = 7;
  localparam int SH    = 4;
  localparam int LAT   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [11:0]       adc5, adc6, ped5, ped6;
  logic              coef_we;
  logic [2:0]        coef_addr;
  logic signed [9:0] coef_data;
  logic              coef_commit;
  logic signed [18:0] cell5, cell6;
  logic              out_valid;

  always #5 clk = ~clk;

  energy_filter dut (
    .clk        (clk),
    .rst        (rst),
    .adc5       (adc5),
    .adc6       (adc6),
    .ped5       (ped5),
    .ped6       (ped6),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_commit(coef_commit),
    .cell5      (cell5),
    .cell6      (cell6),
    .out_valid  (out_valid)
  );

  int ncmp = 0;
  int nbad = 0;

  // Behavioural model state
  int m_shadow [NT];
  int m_active [NT];
  int xh5[$], xh6[$];
  int yq5[$], yq6[$];
  int nsamp;
  int exp5, exp6;
  int exp_valid;
  bit model_ok = 1'b0;

  function automatic int sat(longint v);
    if (v > 262143) return 262143;
    else if (v < -262144) return -262144;
    else return int'(v);
  endfunction

  task automatic model_edge();
    longint acc5, acc6;
    if (rst) begin
      xh5.delete(); xh6.delete(); yq5.delete(); yq6.delete();
      for (int k = 0; k < NT; k++) begin
        xh5.push_back(0); xh6.push_back(0);
        m_shadow[k] = (k == 0) ? 16 : 0;
        m_active[k] = (k == 0) ? 16 : 0;
      end
      for (int k = 0; k < LAT; k++) begin
        yq5.push_back(0); yq6.push_back(0);
      end
      nsamp = 0; exp5 = 0; exp6 = 0; exp_valid = 0;
      model_ok = 1'b1;
    end else begin
      if (coef_commit) m_active = m_shadow;
      if (coef_we && int'(coef_addr) < NT) m_shadow[coef_addr] = int'(coef_data);
      xh5.push_front(int'(adc5) - int'(ped5)); void'(xh5.pop_back());
      xh6.push_front(int'(adc6) - int'(ped6)); void'(xh6.pop_back());
      acc5 = 0; acc6 = 0;
      for (int k = 0; k < NT; k++) begin
        acc5 += longint'(m_active[k]) * longint'(xh5[k]);
        acc6 += longint'(m_active[k]) * longint'(xh6[k]);
      end
      yq5.push_back(sat(acc5 >>> SH));
      yq6.push_back(sat(acc6 >>> SH));
      exp5 = yq5.pop_front();
      exp6 = yq6.pop_front();
      exp_valid = (nsamp >= NT + 3) ? 1 : 0;
      if (nsamp < 1000) nsamp++;
    end
  endtask

  task automatic check(string name, int act, int expv);
    ncmp++;
    if (act != expv) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic compare();
    if (model_ok) begin
      check("model_cell5", int'(cell5), exp5);
      check("model_cell6", int'(cell6), exp6);
      check("model_out_valid", int'(out_valid), exp_valid);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic wcoef(int addr, int data, bit commit);
    coef_we     = 1'b1;
    coef_addr   = addr[2:0];
    coef_data   = data[9:0];
    coef_commit = commit;
    cycle();
    coef_we     = 1'b0;
    coef_commit = 1'b0;
  endtask

  task automatic commit_pulse();
    coef_commit = 1'b1;
    cycle();
    coef_commit = 1'b0;
  endtask

  int fir_tab [NT] = '{1, 2, 3, 4, 3, 2, 1};
  int imp_tab [8]  = '{10, 20, 30, 40, 30, 20, 10, 0};
  int rv;

  initial begin
    rst = 1'b1; adc5 = '0; adc6 = '0; ped5 = '0; ped6 = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
    cycle();
    cycle();
    check("reset_cell5", int'(cell5), 0);
    check("reset_cell6", int'(cell6), 0);
    check("reset_valid", int'(out_valid), 0);

    // Default pass-through with a pedestal step
    rst = 1'b0; ped5 = 12'd100;
    for (int e = 0; e < 30; e++) begin
      adc5 = (e >= 20) ? 12'd600 : 12'd100;
      adc6 = 12'($urandom_range(0, 4095));
      ped6 = 12'($urandom_range(0, 4095));
      cycle();
      if (e == 9)  check("valid_edge9", int'(out_valid), 0);
      if (e == 10) check("valid_edge10", int'(out_valid), 1);
      if (e == 23) check("step_edge23", int'(cell5), 0);
      if (e == 24) check("step_edge24", int'(cell5), 500);
    end

    // Impulse response with a symmetric kernel
    for (int k = 0; k < NT; k++) wcoef(k, fir_tab[k], 1'b0);
    commit_pulse();
    adc6 = '0; ped6 = '0;
    repeat (12) cycle();
    for (int j = 0; j < 12; j++) begin
      adc6 = (j == 0) ? 12'd160 : 12'd0;
      cycle();
      if (j >= 4) check("impulse", int'(cell6), imp_tab[j-4]);
    end

    // Saturation at both rails
    for (int k = 0; k < NT; k++) wcoef(k, 511, 1'b0);
    commit_pulse();
    adc5 = 12'd4095; ped5 = 12'd0; adc6 = 12'd0; ped6 = 12'd4095;
    repeat (12) cycle();
    check("sat_pos", int'(cell5), 262143);
    check("sat_neg", int'(cell6), -262144);

    // Commit timing
    for (int k = 0; k < NT; k++) wcoef(k, (k == 0) ? 16 : 0, 1'b0);
    commit_pulse();
    adc5 = 12'd1000; ped5 = 12'd0; adc6 = 12'd1000; ped6 = 12'd0;
    repeat (12) cycle();
    check("commit_pre", int'(cell5), 1000);
    wcoef(0, 32, 1'b0);
    for (int j = 0; j < 8; j++) begin
      coef_commit = (j == 0);
      cycle();
      coef_commit = 1'b0;
      check("commit_timing5", int'(cell5), (j <= 3) ? 1000 : 2000);
      check("commit_timing6", int'(cell6), (j <= 3) ? 1000 : 2000);
    end

    // Same-cycle write and commit: commit takes the pre-write shadow
    wcoef(0, 48, 1'b1);
    for (int j = 0; j < 8; j++) begin
      cycle();
      check("same_cycle_keep", int'(cell5), 2000);
    end
    for (int j = 0; j < 8; j++) begin
      coef_commit = (j == 0);
      cycle();
      coef_commit = 1'b0;
      check("second_commit", int'(cell5), (j <= 3) ? 2000 : 3000);
    end

    // Out-of-range address is ignored
    wcoef(7, 100, 1'b0);
    wcoef(7, -5, 1'b1);
    for (int j = 0; j < 8; j++) begin
      cycle();
      check("addr7_noop", int'(cell6), 3000);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      adc5 = 12'($urandom_range(0, 4095));
      adc6 = 12'($urandom_range(0, 4095));
      ped5 = 12'($urandom_range(0, 400));
      ped6 = ($urandom_range(0, 7) == 0) ? 12'd4095 : 12'($urandom_range(0, 400));
      coef_we   = ($urandom_range(0, 2) == 0);
      coef_addr = 3'($urandom_range(0, 7));
      rv = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1023)) - 512
                                       : int'($urandom_range(0, 63)) - 32;
      coef_data   = rv[9:0];
      coef_commit = ($urandom_range(0, 7) == 0);
      cycle();
    end

    // Mid-stream reset, with coefficient traffic that must lose to reset
    rst = 1'b1; coef_we = 1'b1; coef_addr = 3'd0; coef_data = 10'sd100; coef_commit = 1'b1;
    cycle();
    check("midrst_cell5", int'(cell5), 0);
    check("midrst_cell6", int'(cell6), 0);
    check("midrst_valid", int'(out_valid), 0);
    rst = 1'b0; coef_we = 1'b0; coef_commit = 1'b0;
    adc5 = 12'd1000; ped5 = 12'd0;
    for (int e = 0; e < 15; e++) begin
      adc6 = 12'($urandom_range(0, 4095));
      cycle();
      if (e == 3)  check("rst_partial", int'(cell5), 0);
      if (e == 4)  check("rst_default_coef", int'(cell5), 1000);
      if (e == 9)  check("rst_valid9", int'(out_valid), 0);
      if (e == 10) check("rst_valid10", int'(out_valid), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/energy_filter.md
# energy_filter

Per-channel matched-filter energy reconstruction for the two tile cells (D5, D6) feeding the muon detection stage. Each clock it takes one 12-bit ADC sample per cell, subtracts a per-channel pedestal, applies an NTAPS FIR with a shared, runtime-reloadable coefficient set, then scales and saturates the result to the 19-bit signed `cell5`/`cell6` energies that the peak/threshold detector consumes directly.

## Interface
- `NTAPS`, 7: FIR length.
- `ADC_W`, 12: unsigned ADC sample width.
- `COEF_W`, 10: signed coefficient width.
- `SHIFT`, 4: arithmetic right shift applied to the accumulator.
- `rst`  in  1: synchronous, active-high reset.
- `clk`  in  1: the single clock, one ADC sample per channel per cycle; everything sampled on the rising edge.
- `adc5`, `adc6`  in  ADC_W: raw unsigned samples.
- `ped5`, `ped6`  in  ADC_W: static pedestals, sampled every cycle.
- `coef_we`  in  1: write strobe into the shadow coefficient bank.
- `coef_addr`  in  3: tap index; values ≥ NTAPS are ignored.
- `coef_data`  in  COEF_W signed: coefficient value.
- `coef_commit`  in  1: single-cycle pulse that copies shadow → active.
- `cell5`, `cell6`  out  19 signed: filtered energies.
- `out_valid`  out  1: high once the full tap window has been filled since reset.

## Operation
- Per channel, with n the edge index: `x[n] = adc - ped` as a 13-bit signed value.
- `y[n] = sat19((Σ_{k=0}^{NTAPS-1} c[k]·x[n-k]) >>> SHIFT)`.
- Widths: product 23 bits, accumulator 26 bits, no intermediate truncation.
- The shift is arithmetic (floor).
- sat19 clamps the result to [-262144, 262143].
- Both channels use the same active coefficient set.
- Shadow bank: when `coef_we` is high, `shadow[coef_addr] <= coef_data`; an out-of-range address is a no-op.
- Commit: `coef_commit` loads all active taps atomically from the shadow contents as they stood before that edge. A `coef_we` in the same cycle updates the shadow only.
- Defaults, applied at reset to both shadow and active banks: c[0] = 2^SHIFT (16), all other taps 0. This gives a pedestal-subtracted pass-through.
- Warm-up counter: counts accepted samples after reset and saturates. `out_valid` is set when the first full window reaches the output (see Timing). Commit does not affect `out_valid`.
- Reset at any time:
  - clears tap registers, pipeline and accumulators;
  - drives `cell5`/`cell6` to 0 and `out_valid` to 0;
  - clears the counter and restores the default coefficients.
- Reset has priority over `coef_we` and `coef_commit`.

## Timing
- Pipeline, where the sample is applied before edge n:
  - edge n: the tap register captures x[n];
  - edge n+1: products;
  - edge n+2: pairwise partial sums;
  - edge n+3: full sum;
  - edge n+4: shift/saturate register.
- Latency: y[n] is visible on `cell5`/`cell6` after edge n+4, i.e. 4 cycles. Outputs are registered.
- Edges are numbered 0 from the first edge with `rst` low. `out_valid` rises after edge NTAPS+3 (edge 10 for NTAPS=7) and stays high until the next reset.
- Taps not yet filled after reset contribute 0. Outputs before `out_valid` are partial sums and are still exact under that rule.
- Commit at edge C: outputs after edge C+4 onward use the new set, outputs up to edge C+3 use the old set. No single output mixes the two sets.
- Back-to-back commits are legal; each one copies the shadow state at its own edge.

## Structure
- Shared package `tmdb_filter_pkg` holds:
  - ADC_W, COEF_W, OUT_W=19, ACC_W=26, SHIFT;
  - the DEFAULT_COEF array;
  - the sat19 limit constants.
- Sub-module `fir_channel`: tap line, products, adder tree and saturation, instanced twice (cell5, cell6).
- The coefficient shadow/active banks and the warm-up counter live in `energy_filter` and fan out to both instances.

## Test plan
- Defaults with ped5=100 and adc5 stepping 100→600 at edge 20 → cell5 = 0 until after edge 23, then 500 from edge 24.
- Load c = {1,2,3,4,3,2,1} then commit, ped6=0, single-cycle impulse adc6=160 at edge n → cell6 sequence after edges n+4…n+10 = 10, 20, 30, 40, 30, 20, 10, then 0.
- Saturation, all c=511:
  - adc=4095, ped=0 → 262143;
  - adc=0, ped=4095 → -262144.
- Commit timing: constant adc=1000, ped=0, switch c[0] from 16 to 32 at edge C → cell = 1000 through edge C+3 and 2000 from edge C+4.
- Same-cycle `coef_we` to addr 0 with `coef_commit` → active c[0] keeps the pre-write shadow value. A second commit applies the new value.
- Writes to addr 7 → no coefficient changes.
- Reset asserted mid-stream for 1 cycle → outputs 0 and `out_valid` 0 on the next edge. Coefficients are back to default. `out_valid` re-rises after edge 10 of the new sequence.
